// File: rtl/fuser_pkg.sv
// Shared types and helpers for the folded majority fuser.
// Optional tie-break on even modality counts is enabled by defining FUSER_TIEBREAK_EN.
package fuser_pkg;

   localparam int unsigned HV_DIMENSION_DEFAULT = 2000;
   // Wide enough for any per-lane sum with up to 15 modalities
   localparam int unsigned SUM_W = 5;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } fuser_state_t;

   function automatic int unsigned acc_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   // Strict majority; an exact tie falls back to tiebit
   function automatic logic majority(input logic [SUM_W-1:0] sum,
                                     input int unsigned n,
                                     input logic tiebit);
      int unsigned dbl;
      dbl = 32'(sum) << 1;
      if (dbl > n) return 1'b1;
      if (dbl == n) return tiebit;
      return 1'b0;
   endfunction

endpackage

// File: rtl/fuser_acc_lane.sv
// One bit lane: modality vote counter plus majority decision on the final beat.
// With FUSER_TIEBREAK_EN a modality-0 bit is kept to resolve even-count ties.
module fuser_acc_lane
   import fuser_pkg::*;
#(
   parameter int unsigned NUM_MODALITY = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic first,
   input  logic hvin_bit,
   output logic fused_c
);

   localparam int unsigned ACC_W = acc_width(NUM_MODALITY);

   logic [ACC_W-1:0] acc_q;
   logic             tie_bit;

   // Modality 0 restarts the count so a stale partial vector never leaks in
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else if (en) begin
         acc_q <= first ? ACC_W'(hvin_bit) : acc_q + ACC_W'(hvin_bit);
      end
   end

`ifdef FUSER_TIEBREAK_EN
   logic tie_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tie_q <= 1'b0;
      end else if (en && first) begin
         tie_q <= hvin_bit;
      end
   end

   assign tie_bit = tie_q;
`else
   assign tie_bit = 1'b0;
`endif

   assign fused_c = majority(SUM_W'(acc_q) + SUM_W'(hvin_bit), NUM_MODALITY, tie_bit);

endmodule

// File: rtl/folded_majority_fuser.sv
// Fuses NUM_MODALITY folded hypervector slices per fold by bitwise majority and
// presents the assembled vector under valid/ready. Tie-break option: FUSER_TIEBREAK_EN.
module folded_majority_fuser
   import fuser_pkg::*;
#(
   parameter  int unsigned HV_DIMENSION = HV_DIMENSION_DEFAULT,
   parameter  int unsigned NUM_MODALITY = 3,
   parameter  int unsigned NUM_FOLDS    = 1,
   localparam int unsigned FOLD_WIDTH   = HV_DIMENSION / NUM_FOLDS,
   localparam int unsigned FOLD_IDX_W   = (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1,
   localparam int unsigned MOD_IDX_W    = $clog2(NUM_MODALITY)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    hvin_valid,
   output logic                    hvin_ready,
   input  logic [FOLD_WIDTH-1:0]   hvin,
   output logic                    hvout_valid,
   input  logic                    hvout_ready,
   output logic [HV_DIMENSION-1:0] hvout,
   output logic [FOLD_IDX_W-1:0]   fold_idx,
   output logic [MOD_IDX_W-1:0]    mod_idx
);

   if (HV_DIMENSION % NUM_FOLDS != 0) begin : g_bad_folds
      $error("HV_DIMENSION must be a multiple of NUM_FOLDS");
   end
   if (NUM_MODALITY < 2 || NUM_MODALITY > 15) begin : g_bad_modality
      $error("NUM_MODALITY must be within 2..15");
   end

   fuser_state_t          state_q;
   logic                  xfer;
   logic                  first_beat;
   logic                  last_mod;
   logic                  last_fold;
   logic                  fold_done;
   logic [FOLD_WIDTH-1:0] fused_c;

   assign xfer       = hvin_valid && hvin_ready;
   assign first_beat = (mod_idx == '0);
   assign last_mod   = (mod_idx == MOD_IDX_W'(NUM_MODALITY - 1));
   assign last_fold  = (fold_idx == FOLD_IDX_W'(NUM_FOLDS - 1));
   assign fold_done  = xfer && last_mod;

   // Beat sequencing and output handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ACCUM;
         hvin_ready  <= 1'b1;
         hvout_valid <= 1'b0;
         mod_idx     <= '0;
         fold_idx    <= '0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (xfer) begin
                  mod_idx <= last_mod ? '0 : mod_idx + MOD_IDX_W'(1);
                  if (last_mod) begin
                     if (last_fold) begin
                        fold_idx    <= '0;
                        state_q     <= HOLD;
                        hvin_ready  <= 1'b0;
                        hvout_valid <= 1'b1;
                     end else begin
                        fold_idx <= fold_idx + FOLD_IDX_W'(1);
                     end
                  end
               end
            end
            HOLD: begin
               if (hvout_ready) begin
                  state_q     <= ACCUM;
                  hvin_ready  <= 1'b1;
                  hvout_valid <= 1'b0;
               end
            end
            default: begin
               state_q     <= ACCUM;
               hvin_ready  <= 1'b1;
               hvout_valid <= 1'b0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < FOLD_WIDTH; i++) begin : g_lane
      fuser_acc_lane #(
         .NUM_MODALITY(NUM_MODALITY)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .en      (xfer),
         .first   (first_beat),
         .hvin_bit(hvin[i]),
         .fused_c (fused_c[i])
      );
   end

   // Each fold owns its slice of hvout; untouched slices keep the previous vector
   for (genvar f = 0; f < NUM_FOLDS; f++) begin : g_fold
      logic [FOLD_WIDTH-1:0] slice_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            slice_q <= '0;
         end else if (fold_done && fold_idx == FOLD_IDX_W'(f)) begin
            slice_q <= fused_c;
         end
      end

      assign hvout[f*FOLD_WIDTH +: FOLD_WIDTH] = slice_q;
   end

endmodule

// File: tb/tb_folded_majority_fuser.sv
// Self-checking bench for folded_majority_fuser: three configurations checked
// against a lane-counting majority reference model.
module tb_folded_majority_fuser;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   a_beats = 0;

   always #5 clk = ~clk;

   // Config A: HV=8, M=3, 4 folds
   logic       a_vin, a_rdy, a_ov, a_ordy;
   logic [1:0] a_hvin, a_fold, a_mod;
   logic [7:0] a_hvout;

   folded_majority_fuser #(.HV_DIMENSION(8), .NUM_MODALITY(3), .NUM_FOLDS(4)) dut_a (
      .clk(clk), .rst(rst), .hvin_valid(a_vin), .hvin_ready(a_rdy), .hvin(a_hvin),
      .hvout_valid(a_ov), .hvout_ready(a_ordy), .hvout(a_hvout),
      .fold_idx(a_fold), .mod_idx(a_mod));

   // Config B: HV=16, M=5, unfolded
   logic        b_vin, b_rdy, b_ov, b_ordy;
   logic [15:0] b_hvin, b_hvout;
   logic [0:0]  b_fold;
   logic [2:0]  b_mod;

   folded_majority_fuser #(.HV_DIMENSION(16), .NUM_MODALITY(5), .NUM_FOLDS(1)) dut_b (
      .clk(clk), .rst(rst), .hvin_valid(b_vin), .hvin_ready(b_rdy), .hvin(b_hvin),
      .hvout_valid(b_ov), .hvout_ready(b_ordy), .hvout(b_hvout),
      .fold_idx(b_fold), .mod_idx(b_mod));

   // Config C: HV=4, M=4 (even, ties possible), unfolded
   logic       c_vin, c_rdy, c_ov, c_ordy;
   logic [3:0] c_hvin, c_hvout;
   logic [0:0] c_fold;
   logic [1:0] c_mod;

   folded_majority_fuser #(.HV_DIMENSION(4), .NUM_MODALITY(4), .NUM_FOLDS(1)) dut_c (
      .clk(clk), .rst(rst), .hvin_valid(c_vin), .hvin_ready(c_rdy), .hvin(c_hvin),
      .hvout_valid(c_ov), .hvout_ready(c_ordy), .hvout(c_hvout),
      .fold_idx(c_fold), .mod_idx(c_mod));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One lane's vote: ones out of m voters
   function automatic logic maj_ref(input int ones, input int m, input logic first_bit);
      if (2 * ones > m) return 1'b1;
`ifdef FUSER_TIEBREAK_EN
      if (2 * ones == m) return first_bit;
`endif
      return 1'b0;
   endfunction

   function automatic logic [7:0] model_a(input logic [1:0] sl [12]);
      logic [7:0] r;
      r = '0;
      for (int f = 0; f < 4; f++) begin
         for (int l = 0; l < 2; l++) begin
            int ones;
            ones = 0;
            for (int m = 0; m < 3; m++) ones += int'(sl[f*3+m][l]);
            r[f*2+l] = maj_ref(ones, 3, sl[f*3][l]);
         end
      end
      return r;
   endfunction

   task automatic a_beat(input logic [1:0] d, input bit gaps);
      int waited;
      if (gaps) begin
         while ($urandom_range(1, 0) == 1) begin
            a_vin  = 1'b0;
            a_hvin = 2'($urandom);
            @(negedge clk);
            chk("stall_mod_idx", 32'(a_mod), 32'(a_beats % 3));
            chk("stall_fold_idx", 32'(a_fold), 32'((a_beats / 3) % 4));
         end
      end
      a_vin  = 1'b1;
      a_hvin = d;
      waited = 0;
      while (a_rdy !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      chk("a_beat_wait_bound", 32'(waited < 50), 32'd1);
      @(negedge clk);
      a_vin = 1'b0;
      a_beats++;
      chk("mod_idx", 32'(a_mod), 32'(a_beats % 3));
      chk("fold_idx", 32'(a_fold), 32'((a_beats / 3) % 4));
   endtask

   task automatic a_vector(input logic [1:0] sl [12], input bit gaps, input int hold_cyc);
      logic [7:0] exp;
      exp = model_a(sl);
      a_ordy = 1'b0;
      for (int i = 0; i < 12; i++) begin
         a_beat(sl[i], gaps);
         if (i % 3 == 2) chk("fold_slice", 32'(a_hvout[(i/3)*2 +: 2]), 32'(exp[(i/3)*2 +: 2]));
         if (i < 11) chk("valid_early", 32'(a_ov), 32'd0);
      end
      chk("out_valid", 32'(a_ov), 32'd1);
      chk("out_hvout", 32'(a_hvout), 32'(exp));
      chk("hold_hvin_ready", 32'(a_rdy), 32'd0);
      for (int k = 0; k < hold_cyc; k++) begin
         a_vin  = 1'b1;
         a_hvin = 2'($urandom);
         @(negedge clk);
         chk("hold_hvin_ready", 32'(a_rdy), 32'd0);
         chk("hold_valid", 32'(a_ov), 32'd1);
         chk("hold_hvout", 32'(a_hvout), 32'(exp));
         chk("hold_mod_idx", 32'(a_mod), 32'd0);
      end
      a_vin  = 1'b0;
      a_ordy = 1'b1;
      @(negedge clk);
      a_ordy = 1'b0;
      chk("release_valid", 32'(a_ov), 32'd0);
      chk("release_ready", 32'(a_rdy), 32'd1);
      chk("release_hvout", 32'(a_hvout), 32'(exp));
   endtask

   task automatic b_send(input logic [15:0] d);
      int waited;
      b_vin  = 1'b1;
      b_hvin = d;
      waited = 0;
      while (b_rdy !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      chk("b_beat_wait_bound", 32'(waited < 50), 32'd1);
      @(negedge clk);
      b_vin = 1'b0;
   endtask

   task automatic c_send(input logic [3:0] d);
      int waited;
      c_vin  = 1'b1;
      c_hvin = d;
      waited = 0;
      while (c_rdy !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      chk("c_beat_wait_bound", 32'(waited < 50), 32'd1);
      @(negedge clk);
      c_vin = 1'b0;
   endtask

   initial begin
      logic [1:0]  sl [12];
      logic [15:0] bs [5];
      logic [3:0]  cs [4];
      logic [15:0] bexp;
      logic [3:0]  cexp;

      rst = 1'b1;
      a_vin = 1'b0; a_hvin = '0; a_ordy = 1'b0;
      b_vin = 1'b0; b_hvin = '0; b_ordy = 1'b1;
      c_vin = 1'b0; c_hvin = '0; c_ordy = 1'b1;
      #1;
      chk("reset_ready", 32'(a_rdy), 32'd1);
      chk("reset_valid", 32'(a_ov), 32'd0);
      chk("reset_hvout", 32'(a_hvout), 32'd0);
      chk("reset_fold_idx", 32'(a_fold), 32'd0);
      chk("reset_mod_idx", 32'(a_mod), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Directed: 11/10/00 per fold gives 10 in every fold
      for (int i = 0; i < 12; i++) sl[i] = (i % 3 == 0) ? 2'b11 : (i % 3 == 1) ? 2'b10 : 2'b00;
      a_vector(sl, 1'b0, 0);
      chk("directed_aa", 32'(a_hvout), 32'hAA);

      // Asynchronous reset after 7 beats of a new vector
      for (int i = 0; i < 7; i++) a_beat(2'($urandom), 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_hvout", 32'(a_hvout), 32'd0);
      chk("async_rst_valid", 32'(a_ov), 32'd0);
      chk("async_rst_ready", 32'(a_rdy), 32'd1);
      chk("async_rst_mod", 32'(a_mod), 32'd0);
      chk("async_rst_fold", 32'(a_fold), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      a_beats = 0;
      for (int i = 0; i < 12; i++) sl[i] = 2'($urandom);
      a_vector(sl, 1'b0, 0);

      // Backpressure: five HOLD cycles, then an unaffected follow-up vector
      for (int i = 0; i < 12; i++) sl[i] = 2'($urandom);
      a_vector(sl, 1'b0, 5);
      for (int i = 0; i < 12; i++) sl[i] = 2'($urandom);
      a_vector(sl, 1'b0, 0);

      // Random gaps and random downstream stalls
      for (int v = 0; v < 3; v++) begin
         for (int i = 0; i < 12; i++) sl[i] = 2'($urandom);
         a_vector(sl, 1'b1, int'($urandom_range(3, 0)));
      end

      // Config B: three all-ones modalities outvote two zero modalities
      bs = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
      for (int i = 0; i < 5; i++) begin
         b_send(bs[i]);
         if (i < 4) chk("b_valid_early", 32'(b_ov), 32'd0);
      end
      chk("b_valid", 32'(b_ov), 32'd1);
      chk("b_hvout_ffff", 32'(b_hvout), 32'hFFFF);
      chk("b_mod_idx", 32'(b_mod), 32'd0);
      for (int v = 0; v < 2; v++) begin
         for (int i = 0; i < 5; i++) bs[i] = 16'($urandom);
         bexp = '0;
         for (int l = 0; l < 16; l++) begin
            int ones;
            ones = 0;
            for (int m = 0; m < 5; m++) ones += int'(bs[m][l]);
            bexp[l] = maj_ref(ones, 5, bs[0][l]);
         end
         for (int i = 0; i < 5; i++) b_send(bs[i]);
         chk("b_rand_valid", 32'(b_ov), 32'd1);
         chk("b_rand_hvout", 32'(b_hvout), 32'(bexp));
      end

      // Config C: even modality count, lane 0 is a 2-2 tie with modality-0 bit set
      cs = '{4'b0101, 4'b1101, 4'b1110, 4'b0010};
      for (int i = 0; i < 4; i++) c_send(cs[i]);
      chk("c_valid", 32'(c_ov), 32'd1);
`ifdef FUSER_TIEBREAK_EN
      chk("c_tie_hvout", 32'(c_hvout), 32'h5);
`else
      chk("c_tie_hvout", 32'(c_hvout), 32'h4);
`endif
      for (int v = 0; v < 3; v++) begin
         for (int i = 0; i < 4; i++) cs[i] = 4'($urandom);
         cexp = '0;
         for (int l = 0; l < 4; l++) begin
            int ones;
            ones = 0;
            for (int m = 0; m < 4; m++) ones += int'(cs[m][l]);
            cexp[l] = maj_ref(ones, 4, cs[0][l]);
         end
         for (int i = 0; i < 4; i++) c_send(cs[i]);
         chk("c_rand_hvout", 32'(c_hvout), 32'(cexp));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/folded_majority_fuser.md
Name: folded_majority_fuser

Overview:
- Parametrised successor to the 3-modality folded fuser.
- Accumulates NUM_MODALITY folded hypervector slices per fold, then majority-thresholds each bit lane.
- Assembles the NUM_FOLDS results into a full HV_DIMENSION output held under a valid/ready handshake.
- Sits between the per-modality spatial/temporal encoders and the associative-memory classifier.

Parameters:
- HV_DIMENSION, 2000: full hypervector width.
- NUM_MODALITY, 3: modality slices fused per fold, range 2..15.
- NUM_FOLDS, 1: folds per hypervector; 1 means unfolded.
- FOLD_WIDTH, HV_DIMENSION/NUM_FOLDS: lanes per fold (localparam). HV_DIMENSION % NUM_FOLDS must equal 0; elaboration error otherwise.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- hvin_valid  in  1  input slice valid
- hvin_ready  out  1  block accepts a slice this cycle
- hvin  in  FOLD_WIDTH  one modality's slice of the current fold
- hvout_valid  out  1  fused hypervector complete
- hvout_ready  in  1  downstream accepts hvout
- hvout  out  HV_DIMENSION  fused hypervector
- fold_idx  out  clog2(NUM_FOLDS) (min 1)  fold currently being accumulated
- mod_idx  out  clog2(NUM_MODALITY)  modality beat expected next

Behaviour:
- Reset (async, immediate):
  - state=ACCUM; mod_idx=0; fold_idx=0.
  - All accumulators=0; hvout=0; hvout_valid=0; hvin_ready=1.
- Input order: fold 0 modality 0..M-1, fold 1 modality 0..M-1, ..., fold NUM_FOLDS-1. A beat transfers on hvin_valid && hvin_ready.
- Accumulator width: ACC_W=clog2(NUM_MODALITY+1). Saturation cannot occur.
- On transfer with mod_idx==0: acc[i] <= hvin[i]. This drops any stale count.
- On other transfers: acc[i] <= acc[i] + hvin[i].
- mod_idx increments per transfer and wraps to 0 after NUM_MODALITY-1.
- On the last-modality transfer, using the updated count:
  - sum = acc[i] + hvin[i].
  - Bit = (2*sum > NUM_MODALITY).
  - Written to hvout[fold_idx*FOLD_WIDTH + i] on the same clock edge. Latency is 1 cycle from the final beat to the slice appearing in hvout.
  - fold_idx increments. On the last fold it wraps to 0 and state goes to HOLD.
- FSM:
  - ACCUM: hvin_ready=1.
  - HOLD: hvin_ready=0; hvout_valid=1; hvout stable.
  - HOLD to ACCUM on hvout_ready. hvin_ready rises the following cycle; a same-cycle hvin beat is not accepted.
- hvout_valid first asserts the cycle after the final beat of the final fold.
- Back-to-back throughput: NUM_FOLDS*NUM_MODALITY + 1 cycles per vector, with hvout_ready tied high.
- hvin_valid low stalls without changing state. Gaps between beats are legal.
- hvout slices not yet rewritten keep the previous vector's bits while in ACCUM. Downstream samples only when hvout_valid is high.
- Even NUM_MODALITY tie (2*sum == NUM_MODALITY) resolves to 0 unless the optional feature is enabled.
- Reset mid-vector discards the partial accumulation. The next beat is treated as fold 0, modality 0.

Optional Feature:
- Macro: FUSER_TIEBREAK_EN.
- Defined:
  - A FOLD_WIDTH register captures hvin on each modality-0 transfer.
  - On a tie, the output bit takes modality 0's bit instead of 0.
  - For odd NUM_MODALITY the register is still present; ties are impossible.
- Undefined:
  - The register is not built.
  - A tie yields 0, i.e. strict majority.

Decomposition:
- Package fuser_pkg holds:
  - HV_DIMENSION default constant.
  - fuser_state_t enum {ACCUM, HOLD}.
  - Function acc_width(n) returning clog2(n+1).
  - Function majority(sum, n, tiebit).
- One natural sub-module: fuser_acc_lane.
  - Contains one lane's ACC_W accumulator, the majority compare and the optional tie bit.
  - Generated FOLD_WIDTH times.
  - Shared mod_idx==0 / last-beat strobes come from the top.

Test Plan:
- HV_DIMENSION=8, NUM_FOLDS=4, M=3; fold slices 2'b11,2'b10,2'b00 repeated for 4 folds, hvout_ready=1 -> hvout=8'b10101010; hvout_valid one cycle after 12th beat, for 1 cycle.
- Same config, hvout_ready=0 for 5 cycles with hvin_valid held high -> hvin_ready=0 and hvout stable for all 5 HOLD cycles; beat count in next vector unaffected.
- M=4, slices 1,1,0,0 (one lane) -> output 0 without FUSER_TIEBREAK_EN; output 1 with it, since modality 0 bit=1.
- Assert rst asynchronously after 7 beats -> all outputs 0 before next clock edge; following 12 beats produce a correct vector from fold 0.
- hvin_valid toggled randomly (50%) over 3 vectors, compared against a scoreboard majority model -> all bits match; fold_idx and mod_idx sequence is correct.
- NUM_FOLDS=1, HV_DIMENSION=16, M=5, all-ones from 3 modalities, zeros from 2 -> hvout=16'hFFFF after 5 beats.
